// File: rtl/pixel_raster_source_if.sv
// rtl/pixel_raster_source_if.sv - upstream sample stream and pixel bus interfaces
interface pixel_stream_if #(
  parameter int PW = 8
);
  logic [PW-1:0] in_pixel;
  logic          in_valid;
  logic          in_ready;

  modport master (output in_pixel, output in_valid, input in_ready);
  modport slave  (input in_pixel, input in_valid, output in_ready);
endinterface

interface pixel_bus_if #(
  parameter int PW = 8
);
  logic [PW-1:0] pixel;
  logic          valid;
  logic [15:0]   row;
  logic [15:0]   col;
  logic          frame_start;

  modport master (output pixel, output valid, output row, output col, output frame_start);
  modport slave  (input pixel, input valid, input row, input col, input frame_start);
endinterface

// File: rtl/pixel_raster_source.sv
// rtl/pixel_raster_source.sv - FIFO-buffered raster pixel bus producer with blanking
module pixel_raster_source #(
  parameter int FP_M       = 8,
  parameter int FP_N       = 0,
  parameter int FP_S       = 0,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  pixel_stream_if.slave  up,
  pixel_bus_if.master    bus,
  output logic           busy
);
  localparam int PW = FP_M + FP_N + FP_S;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] COL_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);
  localparam logic [15:0] HB_LAST  = 16'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [15:0] VB_LAST  = 16'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  localparam logic [AW:0] FULL     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t        state;
  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [15:0]   row_cnt;
  logic [15:0]   col_cnt;
  logic [15:0]   blank_cnt;
  logic          s1_valid;
  logic [PW-1:0] s1_data;
  logic [15:0]   s1_row;
  logic [15:0]   s1_col;

  assign up.in_ready = (count != FULL);
  assign push        = up.in_valid && up.in_ready;
  assign pop         = (state == ACTIVE) && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up.in_pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Popped samples land in s1 with their coordinates; the bus registers follow one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      blank_cnt <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_row    <= '0;
      s1_col    <= '0;
    end else begin
      s1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= ACTIVE;
            busy    <= 1'b1;
            row_cnt <= '0;
            col_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (pop) begin
            s1_valid <= 1'b1;
            s1_data  <= mem[rd_ptr];
            s1_row   <= row_cnt;
            s1_col   <= col_cnt;
            if (col_cnt != COL_LAST) begin
              col_cnt <= col_cnt + 1'b1;
            end else begin
              col_cnt   <= '0;
              blank_cnt <= '0;
              if (row_cnt != ROW_LAST) begin
                row_cnt <= row_cnt + 1'b1;
                if (H_BLANK != 0) state <= HBLANK;
              end else begin
                row_cnt <= '0;
                if (V_BLANK != 0) begin
                  state <= VBLANK;
                end else if (!enable) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
        end
        HBLANK: begin
          if (blank_cnt == HB_LAST) state <= ACTIVE;
          else blank_cnt <= blank_cnt + 1'b1;
        end
        VBLANK: begin
          if (blank_cnt == VB_LAST) begin
            if (enable) begin
              state <= ACTIVE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pixel       <= '0;
      bus.valid       <= 1'b0;
      bus.row         <= '0;
      bus.col         <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.valid       <= s1_valid;
      bus.frame_start <= s1_valid && (s1_row == '0) && (s1_col == '0);
      if (s1_valid) begin
        bus.pixel <= s1_data;
        bus.row   <= s1_row;
        bus.col   <= s1_col;
      end
    end
  end
endmodule
